// File: rtl/addsub_share_arb.sv
// Shares one registered add/subtract unit between two requesters with a tagged response channel.
// Define ADDSUB_SHARE_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module addsub_share_arb #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic             rsp_id
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH:0]   result;

    // Handshake: a request transfers on a cycle where reqN_valid and reqN_ready are both
    // high at posedge; the response transfers where rsp_valid and rsp_ready are both high.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ADDSUB_SHARE_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // The slot frees up in the same cycle the held result is consumed, giving 1 op/cycle.
    assign slot_free  = (state == IDLE) || rsp_ready;
    assign req0_ready = rst_n && slot_free && grant_vld && !grant_id;
    assign req1_ready = rst_n && slot_free && grant_vld && grant_id;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign op_a   = grant_id ? req1_a   : req0_a;
    assign op_b   = grant_id ? req1_b   : req0_b;
    assign op_sub = grant_id ? req1_sub : req0_sub;

    // Bit WIDTH is the carry for add and the borrow (a < b) for subtract.
    assign result = op_sub ? ({1'b0, op_a} - {1'b0, op_b})
                           : ({1'b0, op_a} + {1'b0, op_b});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = HOLD;
            end
            HOLD: begin
                if (accept)         state_nx = HOLD;
                else if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            rsp_flag   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= grant_id;
                rsp_data   <= result[WIDTH-1:0];
                rsp_flag   <= result[WIDTH];
                rsp_id     <= grant_id;
            end
        end
    end

    assign rsp_valid = (state == HOLD);

endmodule

// File: tb/tb_addsub_share_arb.sv
// Scoreboarded bench for addsub_share_arb: driver predicts grants and pushes expected
// responses; an independent monitor checks every presented response against the queue.
module tb_addsub_share_arb;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_flag, rsp_id;
    logic [W-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    // Expected response packed as {id, flag, data}.
    logic [W+1:0] exp_q[$];

    // Reference state: whether a result is outstanding and who was granted last.
    logic model_hold;
    logic model_last;

    addsub_share_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] ref_op(input logic id, input int a, input int b, input logic sub);
        int r;
        logic flag;
        logic [W-1:0] d;
        if (sub) begin
            r    = a - b;
            flag = (a < b);
            if (r < 0) r = r + (1 << W);
        end else begin
            r    = a + b;
            flag = (r >= (1 << W));
            r    = r % (1 << W);
        end
        d = W'(r);
        return {id, flag, d};
    endfunction

    // Winner among the valid requesters, or -1 when nobody asks.
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
`ifdef ADDSUB_SHARE_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (last == 1'b0) ? 1 : 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic step(input logic rn,
                        input logic v0, input int a0, input int b0, input logic s0,
                        input logic v1, input int a1, input int b1, input logic s1,
                        input logic rr);
        int  g;
        logic free;
        logic e0, e1;
        @(negedge clk);
        rst_n = rn; rsp_ready = rr;
        req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0); req0_sub = s0;
        req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1); req1_sub = s1;
        #1;
        free = rn && (!model_hold || rr);
        g    = pick(v0, v1, model_last);
        e0   = free && (g == 0);
        e1   = free && (g == 1);
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
        @(posedge clk);
        if (!rn) begin
            model_hold = 1'b0;
            model_last = 1'b1;
            exp_q.delete();
        end else if (e0 || e1) begin
            if (e0) exp_q.push_back(ref_op(1'b0, a0, b0, s0));
            else    exp_q.push_back(ref_op(1'b1, a1, b1, s1));
            model_hold = 1'b1;
            model_last = e1;
        end else if (model_hold && rr) begin
            model_hold = 1'b0;
        end
    endtask

    // Monitor: sampled after the driver has settled this cycle's inputs.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("rsp_valid", int'(rsp_valid), int'(exp_q.size() != 0));
            if (rsp_valid && exp_q.size() != 0) begin
                chk("rsp_id",   int'(rsp_id),   int'(exp_q[0][W+1]));
                chk("rsp_flag", int'(rsp_flag), int'(exp_q[0][W]));
                chk("rsp_data", int'(rsp_data), int'(exp_q[0][W-1:0]));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        model_hold = 1'b0;
        model_last = 1'b1;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;

        // Reset with both requesters asking.
        step(0, 1, 1, 1, 0, 1, 2, 2, 0, 1);
        step(0, 1, 1, 1, 0, 1, 2, 2, 0, 1);
        #1;
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_data",  int'(rsp_data), 0);
        chk("reset rsp_flag",  int'(rsp_flag), 0);
        chk("reset rsp_id",    int'(rsp_id), 0);

        // First tie after reset goes to req0; then a single op 1+2.
        step(1, 1, 1, 2, 0, 1, 3, 3, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 2, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Wrap-around: 3+1 and 0-1 from req1.
        step(1, 0, 0, 0, 0, 1, 3, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Sustained contention with the consumer always ready.
        for (int i = 0; i < 8; i++) step(1, 1, i % 4, 3, i[0], 1, 3, i % 4, ~i[0], 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: 2+2 held for 3 cycles while req1 waits.
        step(1, 1, 2, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, 3, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1, 3, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset while a result is held: it must vanish.
        step(1, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midreset rsp_valid", int'(rsp_valid), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with random backpressure and dropped requests.
        for (int i = 0; i < 400; i++) begin
            step(1, logic'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("drained queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/addsub_share_arb.md
Name: addsub_share_arb

Overview:
- Arbiter/sequencer that shares one registered WIDTH-bit add/subtract datapath between two requesters.
- Each requester presents operands plus an op select over a valid/ready handshake.
- The block grants one requester at a time, computes on the shared unit, and returns the result tagged with the requester id over a single valid/ready response channel.
- Sits between client blocks and the add/sub pipeline stage so that only one adder/subtractor is instantiated.

Parameters:
- WIDTH, 2, operand/result width in bits.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_sub  input  1  requester 0 op: 0 = A+B, 1 = A-B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result, mod 2^WIDTH.
- rsp_flag  output  1  carry-out for add; borrow (A<B unsigned) for sub.
- rsp_id  output  1  id of the requester that issued the op.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; rsp_valid=0; rsp_data=0; rsp_flag=0; rsp_id=0; last_grant=1 (so requester 0 wins the first tie). Reset mid-operation drops the in-flight result with no response.
- State machine has two states: IDLE (no result held) and HOLD (result held on rsp_*).
- Define "slot free" = (state==IDLE) or (state==HOLD and rsp_ready). reqN_ready is combinational: reqN_ready = slot_free and grant==N.
- Grant is round-robin:
  - If only one valid, that one is granted.
  - If both valid, the requester other than last_grant is granted.
  - If neither valid, there is no grant and both readys are 0.
- Acceptance = reqN_valid and reqN_ready. On acceptance at edge T:
  - rsp_data = (a op b)[WIDTH-1:0].
  - rsp_flag = bit WIDTH of the (WIDTH+1)-bit sum, or (a<b) for sub.
  - rsp_id = N; rsp_valid=1; state=HOLD; last_grant=N.
- Latency: result is visible in the cycle after acceptance (1 cycle).
- HOLD:
  - rsp_data, rsp_flag and rsp_id stay stable while rsp_valid and !rsp_ready.
  - On rsp_ready with a new acceptance in the same cycle, load the new result and stay in HOLD (back-to-back, throughput 1/cycle).
  - On rsp_ready with no acceptance, rsp_valid=0 and go to IDLE; data fields keep their last value.
- Request inputs are sampled only at acceptance. A requester may drop valid before being accepted with no effect.
- IDLE with rsp_ready asserted has no effect.
- Wrap-around: with WIDTH=2, 3+1 gives data 0, flag 1; 0-1 gives data 3, flag 1.

Optional Feature:
- Macro: ADDSUB_SHARE_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, requester 0 always wins ties. last_grant is still updated but ignored by the grant logic.
- When undefined: round-robin as above.
- Ports and latency are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both valids high -> rsp_valid=0, both readys 0, rsp_data=0; first grant after release goes to req0.
- Single op, WIDTH=2: req0 a=1 b=2 sub=0, rsp_ready=1 -> next cycle rsp_valid=1, data=3, flag=0, id=0; following cycle rsp_valid=0.
- Wrap/borrow: req1 a=3 b=1 add -> data=0 flag=1 id=1; then req1 a=0 b=1 sub -> data=3 flag=1.
- Contention, round-robin: both valid continuously, rsp_ready=1 -> ids alternate 0,1,0,1 with one result per cycle. With ADDSUB_SHARE_ARB_FIXED_PRIO_EN defined -> ids 0,0,0,0.
- Backpressure: accept req0 (2+2), hold rsp_ready=0 for 3 cycles with req1 valid -> rsp stays data=0 flag=1 id=0, req1_ready=0; raise rsp_ready -> req1 accepted in that cycle and its result appears the next cycle.
- Mid-op reset: accept an op, assert rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0 and no stale result appears after release.
